// File: rtl/icmp_tx_streamer_if.sv
// Byte stream from the ICMP transmit streamer to the MAC transmit port.
// A byte moves on a cycle where mac_tx_valid and mac_tx_ready are both high.
interface icmp_tx_streamer_if;
  logic [7:0] mac_tx_data;
  logic       mac_tx_valid;
  logic       mac_tx_last;
  logic       mac_tx_ready;

  modport master (
    output mac_tx_data,
    output mac_tx_valid,
    output mac_tx_last,
    input  mac_tx_ready
  );

  modport slave (
    input  mac_tx_data,
    input  mac_tx_valid,
    input  mac_tx_last,
    output mac_tx_ready
  );
endinterface

// File: rtl/icmp_tx_streamer.sv
// Buffers a reply frame, streams it to the MAC zero-padded to MIN_FRAME; byte 0 is valid 2 cycles after the xmit edge.
// mac_tx_ready low holds data/last and stalls the read pointer; GAP_CYCLES idle cycles follow each frame.
module icmp_tx_streamer #(
  parameter int MIN_FRAME  = 60,
  parameter int GAP_CYCLES = 12
) (
  input  logic        mac_clk,
  input  logic        reset,
  input  logic [7:0]  packet_in_data,
  input  logic [9:0]  packet_in_addr,
  input  logic        packet_in_we,
  input  logic [9:0]  packet_in_len,
  input  logic        packet_in_xmit,
  output logic        tx_busy,
  output logic [15:0] tx_frame_count,
  icmp_tx_streamer_if.master mac_tx
);

  localparam int              GW      = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GW-1:0]   GAP_END = GW'(GAP_CYCLES - 1);
  localparam logic [10:0]     MIN_END = 11'(MIN_FRAME - 1);

  typedef enum logic [2:0] {IDLE, PRIME, SEND, PAD, GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [0:1023];
  logic [7:0]    rd_data;
  logic [9:0]    rd_addr;
  logic [10:0]   idx;
  logic [10:0]   last_idx;
  logic [10:0]   frame_end;
  logic [10:0]   pres_idx;
  logic [GW-1:0] gap_cnt;
  logic          xmit_d;
  logic          xmit_armed;
  logic          xmit_edge;
  logic          present;
  logic          hs;
  logic          at_end;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_last;

  assign mac_tx.mac_tx_data  = out_data;
  assign mac_tx.mac_tx_valid = out_valid;
  assign mac_tx.mac_tx_last  = out_last;

  // xmit_armed blocks a false edge when packet_in_xmit is already high at reset release.
  assign xmit_edge = xmit_armed & packet_in_xmit & ~xmit_d;
  assign hs        = out_valid & mac_tx.mac_tx_ready;
  assign frame_end = (last_idx >= MIN_END) ? last_idx : MIN_END;
  assign at_end    = (idx == frame_end);

  always_ff @(posedge mac_clk) begin
    if (packet_in_we && !tx_busy)
      mem[packet_in_addr] <= packet_in_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge mac_clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // rd_data always holds the byte after the one on the output, so a handshake can reload every cycle.
  always_comb begin
    state_nxt = state;
    present   = 1'b0;
    pres_idx  = idx + 11'd1;
    rd_addr   = 10'(idx + 11'd1);
    case (state)
      IDLE: begin
        rd_addr = '0;
        if (xmit_edge)
          state_nxt = PRIME;
      end
      PRIME: begin
        present   = 1'b1;
        pres_idx  = '0;
        rd_addr   = 10'd1;
        state_nxt = SEND;
      end
      SEND, PAD: begin
        if (hs) begin
          rd_addr = 10'(idx + 11'd2);
          if (at_end) begin
            state_nxt = GAP;
          end else begin
            present   = 1'b1;
            state_nxt = (pres_idx <= last_idx) ? SEND : PAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_END)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mac_clk or posedge reset) begin
    if (reset) begin
      xmit_d     <= 1'b0;
      xmit_armed <= 1'b0;
      tx_busy    <= 1'b0;
      last_idx   <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      xmit_d     <= packet_in_xmit;
      xmit_armed <= 1'b1;
      tx_busy    <= (state_nxt != IDLE);
      if (state == IDLE && xmit_edge)
        last_idx <= {1'b0, packet_in_len};
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (present) begin
        idx       <= pres_idx;
        out_data  <= (pres_idx <= last_idx) ? rd_data : 8'h00;
        out_last  <= (pres_idx == frame_end);
        out_valid <= 1'b1;
      end else if (hs && at_end) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge mac_clk or posedge reset) begin
    if (reset)
      tx_frame_count <= '0;
    else if (hs && at_end)
      tx_frame_count <= tx_frame_count + 16'd1;
  end

endmodule

// File: tb/tb_icmp_tx_streamer.sv
// Directed bench for icmp_tx_streamer: table of frames plus hand-written reset and counter-wrap sequences.
module tb_icmp_tx_streamer;

  logic        mac_clk;
  logic        reset;
  logic [7:0]  packet_in_data;
  logic [9:0]  packet_in_addr;
  logic        packet_in_we;
  logic [9:0]  packet_in_len;
  logic        packet_in_xmit;
  logic        tx_busy;
  logic [15:0] tx_frame_count;

  icmp_tx_streamer_if mac_if ();

  icmp_tx_streamer #(.MIN_FRAME(60), .GAP_CYCLES(12)) dut (
    .mac_clk        (mac_clk),
    .reset          (reset),
    .packet_in_data (packet_in_data),
    .packet_in_addr (packet_in_addr),
    .packet_in_we   (packet_in_we),
    .packet_in_len  (packet_in_len),
    .packet_in_xmit (packet_in_xmit),
    .tx_busy        (tx_busy),
    .tx_frame_count (tx_frame_count),
    .mac_tx         (mac_if.master)
  );

  initial mac_clk = 1'b0;
  always #5 mac_clk = ~mac_clk;

  typedef struct {
    int len;
    int mode;      // 0: ready always high, 1: pseudo-random ready
    int hold;      // cycles packet_in_xmit stays high
    bit disturb;   // pulse xmit and write addr 5 mid-frame
    int exp_n;
    int exp_count;
  } vec_t;

  vec_t       vt [8];
  logic [7:0] tb_mem [1024];
  int         checks;
  int         errors;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int len);
    return (i <= len) ? tb_mem[i] : 8'h00;
  endfunction

  task automatic step;
    @(posedge mac_clk);
    #1;
  endtask

  // Called 1ns after a rising edge; returns 1ns after a rising edge.
  task automatic send_frame(input int len, input int mode, input int hold, input bit disturb,
                            input int exp_n, input int exp_count, input string tag);
    int         hs_n;
    int         st;
    int         gap;
    bit         done;
    bit         pstall;
    bit         vseen;
    logic [7:0] pd;
    logic       pl;
    packet_in_len  = len[9:0];
    packet_in_xmit = 1'b1;
    step();
    st = 1;
    chk({tag, " busy_t1"}, tx_busy, 1);
    chk({tag, " valid_t1"}, mac_if.mac_tx_valid, 0);
    if (st >= hold) packet_in_xmit = 1'b0;
    step();
    st++;
    chk({tag, " valid_t2"}, mac_if.mac_tx_valid, 1);
    chk({tag, " byte0_t2"}, mac_if.mac_tx_data, exp_byte(0, len));
    hs_n   = 0;
    done   = 0;
    pstall = 0;
    pd     = 8'h00;
    pl     = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      if (st >= hold) packet_in_xmit = 1'b0;
      if (disturb && st == 10) begin
        packet_in_xmit = 1'b1;
        packet_in_we   = 1'b1;
        packet_in_addr = 10'd5;
        packet_in_data = 8'hFF;
      end
      if (disturb && st == 11) packet_in_we = 1'b0;
      if (pstall) begin
        chk({tag, " hold_valid"}, mac_if.mac_tx_valid, 1);
        chk({tag, " hold_data"}, mac_if.mac_tx_data, pd);
        chk({tag, " hold_last"}, mac_if.mac_tx_last, pl);
      end
      mac_if.mac_tx_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mac_if.mac_tx_valid && mac_if.mac_tx_ready) begin
        chk($sformatf("%s data[%0d]", tag, hs_n), mac_if.mac_tx_data, exp_byte(hs_n, len));
        chk($sformatf("%s last[%0d]", tag, hs_n), mac_if.mac_tx_last, (hs_n == exp_n - 1));
        if (mac_if.mac_tx_last) done = 1;
        hs_n++;
      end
      pstall = mac_if.mac_tx_valid && !mac_if.mac_tx_ready;
      pd     = mac_if.mac_tx_data;
      pl     = mac_if.mac_tx_last;
      step();
      st++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: got %0d handshakes, no last byte", tag, hs_n);
    end
    packet_in_xmit = 1'b0;
    chk({tag, " handshakes"}, hs_n, exp_n);
    chk({tag, " valid_after_last"}, mac_if.mac_tx_valid, 0);
    chk({tag, " count"}, tx_frame_count, exp_count);
    gap   = 0;
    vseen = 0;
    while (tx_busy !== 1'b0 && gap < 200) begin
      step();
      gap++;
      if (mac_if.mac_tx_valid) vseen = 1;
    end
    chk({tag, " gap_cycles"}, gap, 12);
    chk({tag, " gap_valid"}, vseen, 0);
    if (hold > 1 || disturb) begin
      vseen = 0;
      for (int c = 0; c < 25; c++) begin
        step();
        if (mac_if.mac_tx_valid || tx_busy) vseen = 1;
      end
      chk({tag, " no_second_frame"}, vseen, 0);
      chk({tag, " count_after_idle"}, tx_frame_count, exp_count);
    end
  endtask

  initial begin
    int  hs_n;
    bit  quiet;
    checks = 0;
    errors = 0;
    vt[0] = '{len: 73,  mode: 0, hold: 1,  disturb: 0, exp_n: 74, exp_count: 1};
    vt[1] = '{len: 41,  mode: 0, hold: 1,  disturb: 0, exp_n: 60, exp_count: 2};
    vt[2] = '{len: 73,  mode: 1, hold: 1,  disturb: 0, exp_n: 74, exp_count: 3};
    vt[3] = '{len: 59,  mode: 0, hold: 1,  disturb: 0, exp_n: 60, exp_count: 4};
    vt[4] = '{len: 58,  mode: 1, hold: 1,  disturb: 0, exp_n: 60, exp_count: 5};
    vt[5] = '{len: 0,   mode: 0, hold: 1,  disturb: 0, exp_n: 60, exp_count: 6};
    vt[6] = '{len: 73,  mode: 0, hold: 1,  disturb: 1, exp_n: 74, exp_count: 7};
    vt[7] = '{len: 73,  mode: 0, hold: 20, disturb: 0, exp_n: 74, exp_count: 8};
    for (int a = 0; a < 1024; a++)
      tb_mem[a] = (a < 74) ? 8'(a) : 8'((a * 37 + 11) & 255);

    reset               = 1'b1;
    packet_in_data      = 8'h00;
    packet_in_addr      = 10'd0;
    packet_in_we        = 1'b0;
    packet_in_len       = 10'd0;
    packet_in_xmit      = 1'b0;
    mac_if.mac_tx_ready = 1'b1;
    #3;
    chk("rst busy", tx_busy, 0);
    chk("rst valid", mac_if.mac_tx_valid, 0);
    chk("rst last", mac_if.mac_tx_last, 0);
    chk("rst data", mac_if.mac_tx_data, 0);
    chk("rst count", tx_frame_count, 0);
    step();
    step();
    reset = 1'b0;
    step();

    for (int a = 0; a < 1024; a++) begin
      packet_in_we   = 1'b1;
      packet_in_addr = 10'(a);
      packet_in_data = tb_mem[a];
      step();
    end
    packet_in_we = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      send_frame(vt[i].len, vt[i].mode, vt[i].hold, vt[i].disturb,
                 vt[i].exp_n, vt[i].exp_count, $sformatf("vec%0d", i));

    // Reset while byte 30 of a frame is on the bus.
    mac_if.mac_tx_ready = 1'b1;
    packet_in_len  = 10'd73;
    packet_in_xmit = 1'b1;
    step();
    packet_in_xmit = 1'b0;
    hs_n = 0;
    for (int c = 0; c < 500 && hs_n < 30; c++) begin
      if (mac_if.mac_tx_valid && mac_if.mac_tx_ready) hs_n++;
      step();
    end
    chk("midrst byte30", mac_if.mac_tx_data, tb_mem[30]);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst valid", mac_if.mac_tx_valid, 0);
    chk("midrst last", mac_if.mac_tx_last, 0);
    chk("midrst busy", tx_busy, 0);
    chk("midrst count", tx_frame_count, 0);
    packet_in_xmit = 1'b1;
    @(posedge mac_clk);
    @(posedge mac_clk);
    #3;
    reset = 1'b0;
    quiet = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (mac_if.mac_tx_valid || tx_busy) quiet = 0;
    end
    chk("release xmit_high no_edge", quiet, 1);
    packet_in_xmit = 1'b0;
    step();
    send_frame(73, 0, 1, 0, 74, 1, "after_reset");

    // Counter wrap, then the largest frame.
    force dut.tx_frame_count = 16'hFFFF;
    step();
    release dut.tx_frame_count;
    step();
    chk("preload count", tx_frame_count, 16'hFFFF);
    send_frame(41, 0, 1, 0, 60, 0, "wrap");
    send_frame(1023, 0, 1, 0, 1024, 1, "len1023");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icmp_tx_streamer.md
# icmp_tx_streamer

Transmit-side stage directly downstream of the ICMP responder. It captures the reply frame the responder writes byte-by-byte into a local 1024-byte buffer. On the responder's transmit strobe it streams the frame to the MAC transmit interface with a valid/ready handshake, zero-padding short frames to the Ethernet minimum and enforcing an inter-frame gap. It also reports busy status and a sent-frame counter.

## Interface
- MIN_FRAME, 60: minimum frame length in bytes, excluding FCS; shorter frames are zero-padded.
- GAP_CYCLES, 12: idle cycles after the last byte before a new frame is accepted.
- mac_clk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- packet_in_data  in  8  byte to store in the buffer.
- packet_in_addr  in  10  buffer write address.
- packet_in_we  in  1  write strobe; ignored while tx_busy=1.
- packet_in_len  in  10  index of the last valid byte (frame length − 1); sampled on the xmit edge.
- packet_in_xmit  in  1  transmit request; acts on its rising edge only.
- tx_busy  out  1  high from the cycle after an accepted xmit edge to the end of the gap.
- mac_tx_data  out  8  byte to the MAC.
- mac_tx_valid  out  1  mac_tx_data is valid.
- mac_tx_last  out  1  marks the final byte of the frame, qualified by mac_tx_valid.
- mac_tx_ready  in  1  MAC accepts the byte when valid and ready are both high.
- tx_frame_count  out  16  count of completed frames; wraps 65535→0.

## Operation
- Buffer: 1024×8 RAM, synchronous write, 1-cycle registered read. Contents are not cleared by reset.
- Writes: when packet_in_we=1 and tx_busy=0, write packet_in_data to packet_in_addr.
- xmit edge detect: register packet_in_xmit as xmit_d. An edge is packet_in_xmit & !xmit_d. An edge while tx_busy=1 is ignored, with no queuing.
- FSM states: IDLE, PRIME, SEND, PAD, GAP.
  - IDLE→PRIME on an edge. Latch last_idx = packet_in_len and issue a RAM read of address 0.
  - PRIME→SEND after 1 cycle. The first byte is loaded into the output register and mac_tx_valid=1.
  - SEND: on each handshake, advance the read pointer and present the next byte. The read is prefetched so that continuous ready gives 1 byte per cycle.
  - SEND exit on the handshake of byte last_idx:
    - If last_idx+1 ≥ MIN_FRAME, that byte carries mac_tx_last=1 and the FSM goes to GAP.
    - Otherwise the FSM goes to PAD.
  - PAD: emit 0x00 bytes at indices last_idx+1 … MIN_FRAME−1. mac_tx_last=1 on index MIN_FRAME−1. Go to GAP after that handshake.
  - GAP: count GAP_CYCLES cycles with valid=0, then go to IDLE with tx_busy=0.
- Output hold: while mac_tx_valid=1 and mac_tx_ready=0, mac_tx_data and mac_tx_last stay stable, the pointer does not advance, and valid stays high.
- Byte-index arithmetic is 11-bit internally, so last_idx=1023 gives a 1024-byte frame with no wrap to 0.
- tx_frame_count increments on the handshake of the byte with mac_tx_last=1.
- A write in the same cycle as an accepted xmit edge is performed, because tx_busy is still 0 in that cycle.

## Timing
- Reset values: tx_busy=0, mac_tx_data=0x00, mac_tx_valid=0, mac_tx_last=0, tx_frame_count=0, FSM=IDLE, xmit_d=0.
- Reset asserted mid-frame: valid, last and busy drop asynchronously. After release the FSM is in IDLE, and packet_in_xmit already high at release does not produce an edge.
- Edge sampled at clock T: tx_busy=1 and FSM=PRIME at T+1; mac_tx_valid=1 with byte 0 at T+2.
- With continuous ready, byte k is presented at T+2+k.
- A frame of N bytes (after padding) with continuous ready behaves as follows:
  - Last handshake at T+1+N.
  - mac_tx_valid=0 from T+2+N.
  - tx_busy falls at T+2+N+GAP_CYCLES.
  - The earliest next accepted edge is at that same cycle.
- Stalls extend all of the above by the number of ready-low cycles spent with valid high.

## Test plan
- Write bytes 0x00..0x49 at addresses 0..73, set len=73, pulse xmit.
  - Required: 74 bytes out matching the buffer, valid first at edge+2, last on byte 73, count=1, busy falls 12 cycles after valid falls.
- Same frame with len=41 (42 bytes).
  - Required: bytes 0..41 from the buffer, then 18 bytes of 0x00, last on byte 59, 60 handshakes total.
- Toggle mac_tx_ready pseudo-randomly on a 74-byte frame.
  - Required: data and last stable while stalled, no byte dropped or duplicated, sequence identical to the unstalled run.
- While busy, pulse xmit again and write 0xFF to address 5.
  - Required: no second frame, and a later retransmit still shows the original byte 5.
  - Hold xmit high for 20 cycles. Required: exactly one frame.
- Assert reset at byte 30 of a frame.
  - Required: valid, last and busy go to 0 the same cycle, count=0.
  - After release a new xmit edge sends a full, correct frame.
- Preload tx_frame_count to 65535 by sending frames (or forcing it), then send one more.
  - Required: count=0.
  - Separately, len=1023: 1024 bytes out, last on byte 1023.
